// File: rtl/fir_serial_sym_sequencer.sv
// Serial symmetric/anti-symmetric FIR: one pre-adder, one multiplier and one
// accumulator are time-shared over the folded tap pairs under a small FSM.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a sample; accept shifts the delay line, k := 0
// S_MAC   | issue folded tap index k = 0..M-1, one per cycle
// S_DRAIN | 3 cycles to flush the pre-add, multiply and accumulate stages
// S_OUT   | dout/valid_out registered on entry, back to S_IDLE
module fir_serial_sym_sequencer #(
  parameter int INPUT_WIDTH = 16,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 37,
  parameter int SYMMETRY    = 0,
  parameter logic signed [COEFF_WIDTH-1:0] COEFFS [NUM_TAPS] = '{
    8'sd8,   8'sd6,   8'sd0,   -8'sd7,  -8'sd10, -8'sd8,  8'sd0,   8'sd10,
    8'sd16,  8'sd12,  8'sd0,   -8'sd16, -8'sd24, -8'sd16, 8'sd0,   8'sd40,
    8'sd80,  8'sd103, 8'sd127, 8'sd103, 8'sd80,  8'sd40,  8'sd0,   -8'sd16,
    -8'sd24, -8'sd16, 8'sd0,   8'sd12,  8'sd16,  8'sd10,  8'sd0,   -8'sd8,
    -8'sd10, -8'sd7,  8'sd0,   8'sd6,   8'sd8},
  parameter int OUTPUT_WIDTH_FULL = INPUT_WIDTH + COEFF_WIDTH + 1 + $clog2((NUM_TAPS + 1) / 2),
  parameter int OUTPUT_WIDTH      = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic signed [INPUT_WIDTH-1:0]  din,
  output logic                           valid_out,
  output logic signed [OUTPUT_WIDTH-1:0] dout,
  output logic                           busy
);

  localparam int M   = (NUM_TAPS + 1) / 2;
  localparam int KW  = (M > 1) ? $clog2(M) : 1;
  localparam int PAW = INPUT_WIDTH + 1;
  localparam int PW  = INPUT_WIDTH + COEFF_WIDTH + 1;
  localparam int FW  = OUTPUT_WIDTH_FULL;
  localparam bit ODD = (NUM_TAPS % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                        state_q, state_d;
  logic [KW-1:0]                 k_q, k_d;
  logic [1:0]                    drain_q, drain_d;
  logic                          accept;
  logic                          issue;
  logic                          load_out;

  logic signed [INPUT_WIDTH-1:0] dl_q [NUM_TAPS];
  logic signed [INPUT_WIDTH-1:0] sel_a, sel_b;
  logic signed [COEFF_WIDTH-1:0] coef_sel, coef_q;
  logic                          centre;
  logic signed [PAW-1:0]         pre_d, pre_q;
  logic                          pre_vld_q, pre_first_q;
  logic signed [PW-1:0]          mul_d, mul_q;
  logic                          mul_vld_q, mul_first_q;
  logic signed [FW-1:0]          mul_ext, acc_q;
  logic signed [OUTPUT_WIDTH-1:0] dout_conv, dout_q;
  logic                          valid_out_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (k_q == KW'(M - 1)) begin
          drain_d = 2'd2;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) state_d = S_OUT;
        else drain_d = drain_q - 2'd1;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign issue    = (state_q == S_MAC);
  assign load_out = (state_q == S_DRAIN) && (drain_q == 2'd0);
  assign ready_in = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);

  // The centre tap of an odd-length filter has no partner and is never doubled.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    coef_sel = '0;
    centre   = 1'b0;
    pre_d    = '0;
    for (int i = 0; i < M; i++) begin
      if (k_q == KW'(i)) begin
        sel_a    = dl_q[i];
        sel_b    = dl_q[NUM_TAPS-1-i];
        coef_sel = COEFFS[i];
        centre   = ODD && (i == M - 1);
      end
    end
    if (centre)             pre_d = PAW'(sel_a);
    else if (SYMMETRY == 1) pre_d = PAW'(sel_a) - PAW'(sel_b);
    else                    pre_d = PAW'(sel_a) + PAW'(sel_b);
  end

  assign mul_d   = PW'(pre_q) * PW'(coef_q);
  assign mul_ext = FW'(mul_q);

  generate
    if (OUTPUT_WIDTH <= FW) begin : g_trunc
      assign dout_conv = acc_q[FW-1 -: OUTPUT_WIDTH];
    end else begin : g_sext
      assign dout_conv = OUTPUT_WIDTH'(acc_q);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      drain_q     <= '0;
      for (int i = 0; i < NUM_TAPS; i++) dl_q[i] <= '0;
      pre_q       <= '0;
      coef_q      <= '0;
      pre_vld_q   <= 1'b0;
      pre_first_q <= 1'b0;
      mul_q       <= '0;
      mul_vld_q   <= 1'b0;
      mul_first_q <= 1'b0;
      acc_q       <= '0;
      dout_q      <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
      if (accept) begin
        dl_q[0] <= din;
        for (int i = 1; i < NUM_TAPS; i++) dl_q[i] <= dl_q[i-1];
      end
      pre_q       <= pre_d;
      coef_q      <= coef_sel;
      pre_vld_q   <= issue;
      pre_first_q <= issue && (k_q == '0);
      mul_q       <= mul_d;
      mul_vld_q   <= pre_vld_q;
      mul_first_q <= pre_first_q;
      // First product of a computation loads; later ones accumulate.
      if (mul_vld_q) acc_q <= mul_first_q ? mul_ext : acc_q + mul_ext;
      valid_out_q <= load_out;
      if (load_out) dout_q <= dout_conv;
    end
  end

  assign valid_out = valid_out_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_fir_serial_sym_sequencer.sv
// Bench for fir_serial_sym_sequencer: directed and random samples checked
// against a plain convolution model of the full (unfolded) impulse response.
module tb_fir_serial_sym_sequencer;

  localparam logic signed [7:0] COEF [37] = '{
    8'sd8,   8'sd6,   8'sd0,   -8'sd7,  -8'sd10, -8'sd8,  8'sd0,   8'sd10,
    8'sd16,  8'sd12,  8'sd0,   -8'sd16, -8'sd24, -8'sd16, 8'sd0,   8'sd40,
    8'sd80,  8'sd103, 8'sd127, 8'sd103, 8'sd80,  8'sd40,  8'sd0,   -8'sd16,
    -8'sd24, -8'sd16, 8'sd0,   8'sd12,  8'sd16,  8'sd10,  8'sd0,   -8'sd8,
    -8'sd10, -8'sd7,  8'sd0,   8'sd6,   8'sd8};
  localparam logic signed [7:0] ACOEF [4] = '{8'sd3, -8'sd2, 8'sd2, -8'sd3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               valid_in = 1'b0;
  logic signed [15:0] din = '0;
  logic               ready_f, vout_f, busy_f, ready_t, vout_t, busy_t;
  logic signed [29:0] dout_f;
  logic signed [25:0] dout_t;

  logic               a_valid = 1'b0;
  logic signed [15:0] a_din = '0;
  logic               a_ready, a_vout, a_busy;
  logic signed [25:0] a_dout;

  fir_serial_sym_sequencer #(.COEFFS(COEF), .OUTPUT_WIDTH(30)) u_full (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_f), .din(din),
    .valid_out(vout_f), .dout(dout_f), .busy(busy_f));

  fir_serial_sym_sequencer #(.COEFFS(COEF), .OUTPUT_WIDTH(26)) u_trunc (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_t), .din(din),
    .valid_out(vout_t), .dout(dout_t), .busy(busy_t));

  fir_serial_sym_sequencer #(.NUM_TAPS(4), .SYMMETRY(1), .COEFFS(ACOEF), .OUTPUT_WIDTH(26)) u_anti (
    .clk(clk), .rst(rst), .valid_in(a_valid), .ready_in(a_ready), .din(a_din),
    .valid_out(a_vout), .dout(a_dout), .busy(a_busy));

  int     n_pass = 0;
  int     n_fail = 0;
  int     n_total = 0;
  longint hist [37];
  longint ahist [4];
  longint exp_f;
  longint exp_a;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total += 1;
    assert (obs === exp) n_pass += 1;
    else begin
      n_fail += 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_main(input longint x);
    longint y = 0;
    for (int j = 36; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = x;
    for (int j = 0; j < 37; j++) y += longint'(COEF[j]) * hist[j];
    return y;
  endfunction

  function automatic longint model_anti(input longint x);
    longint y = 0;
    for (int j = 3; j > 0; j--) ahist[j] = ahist[j-1];
    ahist[0] = x;
    for (int j = 0; j < 4; j++) y += longint'(ACOEF[j]) * ahist[j];
    return y;
  endfunction

  task automatic clear_models();
    for (int j = 0; j < 37; j++) hist[j] = 0;
    for (int j = 0; j < 4; j++) ahist[j] = 0;
  endtask

  // Returns at the negedge of cycle T+1, T being the accept cycle.
  task automatic main_accept(input logic signed [15:0] x);
    int n = 0;
    while (ready_f !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("main_ready_wait", ready_f, 1);
    valid_in = 1'b1;
    din      = x;
    exp_f    = model_main(x);
    @(negedge clk);
    valid_in = 1'b0;
    din      = 16'($urandom);
  endtask

  task automatic main_result(input bit chk_timing);
    int n = 1;
    while (vout_f !== 1'b1 && n < 60) begin
      if (chk_timing) begin
        check("ready_low", ready_f, 0);
        check("busy_high", busy_f, 1);
      end
      @(negedge clk);
      n++;
    end
    check("vout_full", vout_f, 1);
    check("vout_trunc", vout_t, 1);
    if (chk_timing) begin
      check("latency", n, 23);
      check("ready_low_out", ready_f, 0);
      check("busy_high_out", busy_f, 1);
    end
    check("dout_full", dout_f, exp_f);
    check("dout_trunc", dout_t, exp_f >>> 4);
    @(negedge clk);
    check("vout_pulse", vout_f, 0);
    check("ready_after", ready_f, 1);
    check("dout_hold", dout_f, exp_f);
  endtask

  task automatic push_main(input logic signed [15:0] x, input bit chk_timing);
    main_accept(x);
    main_result(chk_timing);
  endtask

  task automatic push_anti(input logic signed [15:0] x);
    int n = 0;
    while (a_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("anti_ready_wait", a_ready, 1);
    a_valid = 1'b1;
    a_din   = x;
    exp_a   = model_anti(x);
    @(negedge clk);
    a_valid = 1'b0;
    a_din   = 16'($urandom);
    n = 1;
    while (a_vout !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    check("anti_vout", a_vout, 1);
    check("anti_latency", n, 6);
    check("anti_dout", a_dout, exp_a);
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc [$];
    int nout;
    int nvout;
    longint pending;
    logic signed [15:0] aimp [5];
    logic signed [7:0]  aexp [5];
    aimp = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    aexp = '{8'sd3, -8'sd2, 8'sd2, -8'sd3, 8'sd0};
    clear_models();

    // Reset with valid_in high: nothing is accepted.
    rst = 1'b0; valid_in = 1'b1; din = 16'sd1234;
    repeat (3) @(negedge clk);
    check("rst_vout", vout_f, 0);
    check("rst_dout", dout_f, 0);
    check("rst_busy", busy_f, 0);
    check("rst_anti_dout", a_dout, 0);
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ready_f, 1);
    check("post_rst_busy", busy_f, 0);
    check("post_rst_anti_ready", a_ready, 1);

    // Impulse, first sample also checks latency and handshake.
    for (int i = 0; i < 37; i++) begin
      push_main((i == 0) ? 16'sd1 : 16'sd0, i == 0);
      check("impulse_coef", dout_f, COEF[i]);
    end

    // DC step, positive then full-scale negative.
    for (int i = 0; i < 37; i++) push_main(16'sd1, 1'b0);
    check("dc_515", dout_f, 515);
    check("trunc_32", dout_t, 32);
    for (int i = 0; i < 37; i++) push_main(16'sh8000, 1'b0);
    check("dc_neg_full", dout_f, -16875520);
    check("dc_neg_trunc", dout_t, -1054720);

    // valid_in held high: one accept per 24 cycles.
    nout = 0;
    valid_in = 1'b1;
    din = 16'($urandom);
    for (int c = 0; c < 72; c++) begin
      if (ready_f === 1'b1) begin
        acc_cyc.push_back(c);
        pending = model_main(din);
      end
      @(negedge clk);
      if (ready_f !== 1'b1) din = 16'($urandom);
      if (vout_f === 1'b1) begin
        check("held_dout", dout_f, pending);
        check("held_trunc", dout_t, pending >>> 4);
        nout++;
      end
    end
    valid_in = 1'b0;
    check("held_accepts", acc_cyc.size(), 3);
    check("held_outputs", nout, 3);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("held_interval", acc_cyc[i] - acc_cyc[i-1], 24);

    // Random samples with idle gaps.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_main(16'($urandom), i == 12);
    end

    // Anti-symmetric engine: impulse then random samples.
    for (int i = 0; i < 5; i++) begin
      push_anti(aimp[i]);
      check("anti_impulse", a_dout, aexp[i]);
    end
    for (int i = 0; i < 20; i++) push_anti(16'($urandom));

    // Reset in the middle of the MAC phase aborts the computation.
    main_accept(16'sd20000);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_models();
    nvout = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (vout_f === 1'b1) nvout++;
    end
    check("abort_no_vout", nvout, 0);
    check("abort_dout", dout_f, 0);
    check("abort_dout_trunc", dout_t, 0);
    check("abort_busy", busy_f, 0);
    for (int i = 0; i < 37; i++) begin
      push_main((i == 0) ? 16'sd1 : 16'sd0, 1'b0);
      check("impulse2_coef", dout_f, COEF[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
